// File: rtl/ts_pkg.sv
// Shared MPEG-2 TS definitions: header field layout, parser states, constants.
package ts_pkg;

    localparam logic [7:0]  SYNC_BYTE  = 8'h47;
    localparam logic [12:0] NULL_PID   = 13'h1FFF;
    localparam int          TS_PKT_LEN = 188;

    localparam logic [1:0] AFC_RESERVED      = 2'b00;
    localparam logic [1:0] AFC_PAYLOAD_ONLY  = 2'b01;
    localparam logic [1:0] AFC_ADAPT_ONLY    = 2'b10;
    localparam logic [1:0] AFC_ADAPT_PAYLOAD = 2'b11;

    typedef struct packed {
        logic        tei;
        logic        pusi;
        logic [12:0] pid;
        logic [1:0]  afc;
        logic [3:0]  cc;
    } ts_hdr_t;

    typedef enum logic [2:0] {
        ST_WAIT,
        ST_H1,
        ST_H2,
        ST_H3,
        ST_EVAL,
        ST_PAYLOAD
    } ts_state_e;

    function automatic logic afc_has_payload(input logic [1:0] afc);
        return (afc == AFC_PAYLOAD_ONLY) || (afc == AFC_ADAPT_PAYLOAD);
    endfunction

endpackage

// File: rtl/ts_pid_table.sv
// Fully associative PID slot table with combinational lookup and one write port.
// The per-slot duplicate flag exists only when TS_CC_DUP_EN is defined.
module ts_pid_table
    import ts_pkg::*;
#(
    parameter int N_PIDS = 8,
    parameter int IDX_W  = (N_PIDS > 1) ? $clog2(N_PIDS) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic [12:0]      lkp_pid,
    output logic             hit,
    output logic [IDX_W-1:0] hit_idx,
    output logic [3:0]       hit_cc,
`ifdef TS_CC_DUP_EN
    output logic             hit_dup,
    input  logic             wr_dup,
`endif
    output logic             free_avail,
    output logic [IDX_W-1:0] free_idx,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [12:0]      wr_pid,
    input  logic [3:0]       wr_cc
);

    logic [N_PIDS-1:0] valid_q;
    logic [12:0]       pid_q [N_PIDS];
    logic [3:0]        cc_q  [N_PIDS];
`ifdef TS_CC_DUP_EN
    logic [N_PIDS-1:0] dup_q;
`endif

    // Clear has priority over a coincident write, so a cleared table stays empty.
    always_ff @(posedge clk) begin
        if (!rst || clr) begin
            valid_q <= '0;
`ifdef TS_CC_DUP_EN
            dup_q   <= '0;
`endif
        end else if (wr_en) begin
            valid_q[wr_idx] <= 1'b1;
`ifdef TS_CC_DUP_EN
            dup_q[wr_idx]   <= wr_dup;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst && !clr && wr_en) begin
            pid_q[wr_idx] <= wr_pid;
            cc_q[wr_idx]  <= wr_cc;
        end
    end

    // Descending scan so the lowest free slot is the one reported.
    always_comb begin
        hit        = 1'b0;
        hit_idx    = '0;
        hit_cc     = '0;
        free_avail = 1'b0;
        free_idx   = '0;
`ifdef TS_CC_DUP_EN
        hit_dup    = 1'b0;
`endif
        for (int i = N_PIDS - 1; i >= 0; i--) begin
            if (valid_q[i] && (pid_q[i] == lkp_pid)) begin
                hit     = 1'b1;
                hit_idx = IDX_W'(i);
                hit_cc  = cc_q[i];
`ifdef TS_CC_DUP_EN
                hit_dup = dup_q[i];
`endif
            end
            if (!valid_q[i]) begin
                free_avail = 1'b1;
                free_idx   = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/ts_cc_monitor.sv
// TS header parser and continuity-counter monitor with saturating statistics.
// Optional duplicate-packet tolerance is enabled by defining TS_CC_DUP_EN.
module ts_cc_monitor
    import ts_pkg::*;
#(
    parameter int N_PIDS = 8,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       byte_in,
    input  logic             byte_valid,
    input  logic             sof,
    input  logic             stat_clr,
    output logic             hdr_valid,
    output logic [12:0]      pid,
    output logic [3:0]       cc,
    output logic             pusi,
    output logic             cc_error,
    output logic             tei_error,
    output logic             table_full,
    output logic [CNT_W-1:0] pkt_count,
    output logic [CNT_W-1:0] cc_err_count,
    output logic [2:0]       dbg_state
);

    localparam int         IDX_W    = (N_PIDS > 1) ? $clog2(N_PIDS) : 1;
    localparam logic [7:0] IDX_IDLE = 8'(TS_PKT_LEN);

    ts_state_e   state_q, state_d;
    logic [7:0]  idx_q;
    logic        tei_q, pusi_q;
    logic [12:0] pid_q;
    ts_hdr_t     hdr;

    logic start, commit, err, full_set;
    logic hit, free_avail, wr_en;
    logic [IDX_W-1:0] hit_idx, free_idx, wr_idx;
    logic [3:0] hit_cc, wr_cc;
`ifdef TS_CC_DUP_EN
    logic hit_dup, wr_dup;
`endif

    // A sync byte always wins, so it also restarts a packet cut short by a new one.
    assign start     = sof & byte_valid;
    assign commit    = (state_q == ST_H3) && byte_valid && !sof;
    assign dbg_state = state_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_WAIT;
            idx_q   <= IDX_IDLE;
        end else begin
            state_q <= state_d;
            if (start) begin
                idx_q <= 8'd1;
            end else if (byte_valid && (idx_q != IDX_IDLE)) begin
                idx_q <= idx_q + 8'd1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        if (start) begin
            state_d = ST_H1;
        end else begin
            case (state_q)
                ST_H1:      if (byte_valid) state_d = ST_H2;
                ST_H2:      if (byte_valid) state_d = ST_H3;
                ST_H3:      if (byte_valid) state_d = ST_EVAL;
                ST_EVAL:    state_d = ST_PAYLOAD;
                ST_PAYLOAD: if (idx_q == IDX_IDLE) state_d = ST_WAIT;
                default:    state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            tei_q  <= 1'b0;
            pusi_q <= 1'b0;
            pid_q  <= '0;
        end else if (byte_valid && !sof) begin
            if (state_q == ST_H1) begin
                tei_q       <= byte_in[7];
                pusi_q      <= byte_in[6];
                pid_q[12:8] <= byte_in[4:0];
            end else if (state_q == ST_H2) begin
                pid_q[7:0]  <= byte_in;
            end
        end
    end

    // Byte 3 is consumed straight off the bus so the verdict registers with it.
    always_comb begin
        hdr.tei  = tei_q;
        hdr.pusi = pusi_q;
        hdr.pid  = pid_q;
        hdr.afc  = byte_in[5:4];
        hdr.cc   = byte_in[3:0];
    end

    ts_pid_table #(.N_PIDS(N_PIDS), .IDX_W(IDX_W)) u_table (
        .clk        (clk),
        .rst        (rst),
        .clr        (stat_clr),
        .lkp_pid    (pid_q),
        .hit        (hit),
        .hit_idx    (hit_idx),
        .hit_cc     (hit_cc),
`ifdef TS_CC_DUP_EN
        .hit_dup    (hit_dup),
        .wr_dup     (wr_dup),
`endif
        .free_avail (free_avail),
        .free_idx   (free_idx),
        .wr_en      (wr_en),
        .wr_idx     (wr_idx),
        .wr_pid     (pid_q),
        .wr_cc      (wr_cc)
    );

    always_comb begin
        err      = 1'b0;
        full_set = 1'b0;
        wr_en    = 1'b0;
        wr_idx   = hit_idx;
        wr_cc    = hdr.cc;
`ifdef TS_CC_DUP_EN
        wr_dup   = 1'b0;
`endif
        if (commit && !hdr.tei && (hdr.pid != NULL_PID)) begin
            if (hit) begin
                if (afc_has_payload(hdr.afc)) begin
                    wr_en = 1'b1;
                    if (hdr.cc == 4'(hit_cc + 4'd1)) begin
                        err = 1'b0;
`ifdef TS_CC_DUP_EN
                    end else if ((hdr.cc == hit_cc) && !hit_dup) begin
                        wr_dup = 1'b1;
`endif
                    end else begin
                        err = 1'b1;
                    end
                end else if (hdr.cc != hit_cc) begin
                    wr_en = 1'b1;
                    err   = 1'b1;
                end
            end else if (free_avail) begin
                wr_en  = 1'b1;
                wr_idx = free_idx;
            end else begin
                full_set = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            hdr_valid    <= 1'b0;
            pid          <= '0;
            cc           <= '0;
            pusi         <= 1'b0;
            cc_error     <= 1'b0;
            tei_error    <= 1'b0;
            table_full   <= 1'b0;
            pkt_count    <= '0;
            cc_err_count <= '0;
        end else begin
            hdr_valid <= commit;
            cc_error  <= err;
            tei_error <= commit & hdr.tei;
            if (commit) begin
                pid  <= hdr.pid;
                cc   <= hdr.cc;
                pusi <= hdr.pusi;
            end
            if (stat_clr) begin
                table_full   <= 1'b0;
                pkt_count    <= '0;
                cc_err_count <= '0;
            end else begin
                if (full_set) table_full <= 1'b1;
                if (commit && (pkt_count != '1)) pkt_count <= pkt_count + 1'b1;
                if (err && (cc_err_count != '1)) cc_err_count <= cc_err_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ts_cc_monitor.sv
// Directed and randomized bench for ts_cc_monitor against a per-PID reference model.
module tb_ts_cc_monitor;

    localparam int N_PIDS  = 8;
    localparam int CNT_W   = 16;
    localparam int CNT_MAX = (1 << CNT_W) - 1;
`ifdef TS_CC_DUP_EN
    localparam bit DUP_EN = 1'b1;
`else
    localparam bit DUP_EN = 1'b0;
`endif

    logic             clk;
    logic             rst;
    logic [7:0]       byte_in;
    logic             byte_valid;
    logic             sof;
    logic             stat_clr;
    logic             hdr_valid;
    logic [12:0]      pid;
    logic [3:0]       cc;
    logic             pusi;
    logic             cc_error;
    logic             tei_error;
    logic             table_full;
    logic [CNT_W-1:0] pkt_count;
    logic [CNT_W-1:0] cc_err_count;
    logic [2:0]       dbg_state;

    int checks = 0;
    int errors = 0;

    // Reference model: learned PIDs in learning order with last CC and dup flag.
    logic [12:0] m_pid[$];
    logic [3:0]  m_cc[$];
    bit          m_dup[$];
    bit          m_full;
    int          m_pkt;
    int          m_err;
    logic [19:0] exp_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    ts_cc_monitor #(.N_PIDS(N_PIDS), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .byte_in      (byte_in),
        .byte_valid   (byte_valid),
        .sof          (sof),
        .stat_clr     (stat_clr),
        .hdr_valid    (hdr_valid),
        .pid          (pid),
        .cc           (cc),
        .pusi         (pusi),
        .cc_error     (cc_error),
        .tei_error    (tei_error),
        .table_full   (table_full),
        .pkt_count    (pkt_count),
        .cc_err_count (cc_err_count),
        .dbg_state    (dbg_state)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        m_pid.delete();
        m_cc.delete();
        m_dup.delete();
        m_full = 1'b0;
        m_pkt  = 0;
        m_err  = 0;
    endtask

    task automatic model_pkt(input logic tei, input logic pu, input logic [12:0] p,
                             input logic [1:0] afc, input logic [3:0] c);
        bit e;
        int j;
        e = 1'b0;
        j = -1;
        if (!tei && p != 13'h1FFF) begin
            foreach (m_pid[k]) if (m_pid[k] == p) j = k;
            if (j < 0) begin
                if (m_pid.size() < N_PIDS) begin
                    m_pid.push_back(p);
                    m_cc.push_back(c);
                    m_dup.push_back(1'b0);
                end else begin
                    m_full = 1'b1;
                end
            end else if (afc == 2'b01 || afc == 2'b11) begin
                if (int'(c) == (int'(m_cc[j]) + 1) % 16) begin
                    m_cc[j]  = c;
                    m_dup[j] = 1'b0;
                end else if (DUP_EN && c == m_cc[j] && !m_dup[j]) begin
                    m_dup[j] = 1'b1;
                end else begin
                    e = 1'b1;
                    m_cc[j]  = c;
                    m_dup[j] = 1'b0;
                end
            end else if (c != m_cc[j]) begin
                e = 1'b1;
                m_cc[j]  = c;
                m_dup[j] = 1'b0;
            end
        end
        if (m_pkt < CNT_MAX) m_pkt++;
        if (e && m_err < CNT_MAX) m_err++;
        exp_q.push_back({e, tei, pu, p, c});
    endtask

    // Drives len bytes of one packet; the header check lands one cycle after byte 3.
    task automatic send_pkt(input logic [7:0] b1, input logic [7:0] b2, input logic [7:0] b3,
                            input int len, input bit gaps, input bit clr_eval);
        int          hv_seen;
        logic [19:0] exp;
        logic [12:0] p;
        hv_seen = 0;
        p = {b1[4:0], b2};
        for (int k = 0; k < len; k++) begin
            if (gaps && k > 0 && $urandom_range(0, 3) == 0) begin
                byte_valid = 1'b0;
                sof        = 1'b0;
                byte_in    = 8'($urandom_range(0, 255));
                step();
                hv_seen += int'(hdr_valid);
            end
            byte_valid = 1'b1;
            sof        = (k == 0);
            stat_clr   = clr_eval && (k == 4);
            case (k)
                0:       byte_in = 8'h47;
                1:       byte_in = b1;
                2:       byte_in = b2;
                3:       byte_in = b3;
                default: byte_in = 8'($urandom_range(0, 255));
            endcase
            step();
            stat_clr = 1'b0;
            if (k == 3) begin
                model_pkt(b1[7], b1[6], p, b3[5:4], b3[3:0]);
                exp = exp_q.pop_front();
                chk("hdr_valid", 32'(hdr_valid), 32'd1);
                chk("hdr_fields", 32'({cc_error, tei_error, pusi, pid, cc}), 32'(exp));
                chk("pkt_count", 32'(pkt_count), 32'(m_pkt));
                chk("cc_err_count", 32'(cc_err_count), 32'(m_err));
                chk("table_full", 32'(table_full), 32'(m_full));
            end else begin
                hv_seen += int'(hdr_valid);
            end
            if (clr_eval && k == 4) begin
                model_clear();
                chk("clr_eval_pkt", 32'(pkt_count), 32'd0);
                chk("clr_eval_full", 32'(table_full), 32'd0);
            end
        end
        byte_valid = 1'b0;
        sof        = 1'b0;
        chk("stray_hdr_valid", 32'(hv_seen), 32'd0);
        if (len >= 4) chk("pid_hold", 32'(pid), 32'(p));
    endtask

    task automatic pkt(input logic tei, input logic pu, input logic [12:0] p,
                       input logic [1:0] afc, input logic [3:0] c, input bit gaps);
        send_pkt({tei, pu, 1'b0, p[12:8]}, p[7:0], {2'b00, afc, c}, 188, gaps, 1'b0);
    endtask

    task automatic pulse_clr();
        stat_clr   = 1'b1;
        byte_valid = 1'b0;
        sof        = 1'b0;
        step();
        stat_clr = 1'b0;
        model_clear();
        chk("clr_pkt", 32'(pkt_count), 32'd0);
        chk("clr_err", 32'(cc_err_count), 32'd0);
        chk("clr_full", 32'(table_full), 32'd0);
    endtask

    task automatic do_reset();
        rst        = 1'b0;
        byte_valid = 1'b0;
        sof        = 1'b0;
        stat_clr   = 1'b0;
        step();
        rst = 1'b1;
        model_clear();
        chk("rst_hdr_valid", 32'(hdr_valid), 32'd0);
        chk("rst_outputs", 32'({pid, cc, pusi, cc_error, tei_error, table_full}), 32'd0);
        chk("rst_counters", 32'({pkt_count, cc_err_count}), 32'd0);
    endtask

    initial begin
        logic [12:0] rp;
        logic [3:0]  rc;
        int          j;
        rst        = 1'b0;
        byte_in    = 8'h00;
        byte_valid = 1'b0;
        sof        = 1'b0;
        stat_clr   = 1'b0;
        model_clear();
        step();
        step();
        do_reset();

        // In-order CC stream on one PID
        for (int i = 0; i < 5; i++) pkt(1'b0, (i == 0), 13'h0100, 2'b01, 4'(i), 1'b0);
        chk("five_pkts_count", 32'(pkt_count), 32'd5);
        chk("five_pkts_errs", 32'(cc_err_count), 32'd0);

        // Gap in CC sequence
        pulse_clr();
        pkt(1'b0, 1'b0, 13'h0100, 2'b01, 4'd3, 1'b0);
        pkt(1'b0, 1'b0, 13'h0100, 2'b01, 4'd4, 1'b0);
        pkt(1'b0, 1'b0, 13'h0100, 2'b01, 4'd6, 1'b0);
        chk("gap_err_count", 32'(cc_err_count), 32'd1);
        pkt(1'b0, 1'b0, 13'h0100, 2'b01, 4'd7, 1'b1);
        chk("gap_recover", 32'(cc_err_count), 32'd1);

        // Repeated CC with payload
        pulse_clr();
        for (int i = 0; i < 3; i++) pkt(1'b0, 1'b0, 13'h0200, 2'b01, 4'd5, 1'b0);
        chk("repeat_errs", 32'(cc_err_count), DUP_EN ? 32'd1 : 32'd2);

        // Adaptation-only packets, then TEI packets that must leave the table alone
        pulse_clr();
        pkt(1'b0, 1'b0, 13'h0300, 2'b10, 4'd9, 1'b0);
        pkt(1'b0, 1'b0, 13'h0300, 2'b10, 4'd9, 1'b0);
        pkt(1'b0, 1'b0, 13'h0300, 2'b01, 4'd10, 1'b0);
        chk("afc10_errs", 32'(cc_err_count), 32'd0);
        send_pkt(8'h80, 8'h00, 8'h15, 188, 1'b0, 1'b0);
        pkt(1'b1, 1'b0, 13'h0300, 2'b01, 4'd3, 1'b0);
        pkt(1'b0, 1'b0, 13'h0300, 2'b01, 4'd11, 1'b0);
        chk("tei_table_untouched", 32'(cc_err_count), 32'd0);

        // Table overflow, null PID, clear
        pulse_clr();
        for (int i = 0; i <= N_PIDS; i++) pkt(1'b0, 1'b0, 13'(16 + i), 2'b01, 4'd0, 1'b0);
        chk("table_full_set", 32'(table_full), 32'd1);
        for (int i = 0; i < 6; i++) pkt(1'b0, 1'b0, 13'h1FFF, 2'b01, 4'($urandom_range(0, 15)), 1'b1);
        chk("null_no_errs", 32'(cc_err_count), 32'd0);
        pulse_clr();
        pkt(1'b0, 1'b0, 13'h0400, 2'b01, 4'd1, 1'b0);
        send_pkt({3'b000, 5'h04}, 8'h00, 8'h13, 188, 1'b0, 1'b1);
        pkt(1'b0, 1'b0, 13'h0400, 2'b01, 4'd9, 1'b0);
        chk("clr_eval_relearn", 32'(cc_err_count), 32'd0);

        // Truncated packets and reset mid-packet
        send_pkt(8'h05, 8'h00, 8'h10, 2, 1'b0, 1'b0);
        pkt(1'b0, 1'b0, 13'h0500, 2'b01, 4'd2, 1'b0);
        send_pkt(8'h05, 8'h00, 8'h13, 3, 1'b0, 1'b0);
        do_reset();
        send_pkt(8'h05, 8'h00, 8'h14, 60, 1'b0, 1'b0);
        do_reset();
        pkt(1'b0, 1'b1, 13'h0500, 2'b01, 4'd7, 1'b0);
        chk("post_reset_count", 32'(pkt_count), 32'd1);

        // Randomized traffic over a small PID pool
        pulse_clr();
        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 5))
                0:       rp = 13'h1FFF;
                1:       rp = 13'($urandom_range(0, 8190));
                default: rp = 13'(13'h0600 + $urandom_range(0, 3));
            endcase
            j = -1;
            foreach (m_pid[k]) if (m_pid[k] == rp) j = k;
            rc = 4'($urandom_range(0, 15));
            if (j >= 0) begin
                case ($urandom_range(0, 3))
                    0, 1:    rc = 4'(m_cc[j] + 4'd1);
                    2:       rc = m_cc[j];
                    default: rc = rc;
                endcase
            end
            pkt(($urandom_range(0, 15) == 0), 1'($urandom_range(0, 1)), rp,
                2'($urandom_range(0, 3)), rc, 1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
